// File: rtl/cpu_stack_writeback.sv
// Stack CPU writeback stage: owns the operand stack and SP, retires pop/push,
// serves two TOS-relative read ports with write bypass, registers the branch
// redirect and holds sticky stack faults.
`ifndef UC_PUSHNONE
`define UC_PUSHNONE 3'd0
`endif

module cpu_stack_writeback #(
  parameter int DEPTH = 256,
  parameter int SP_W  = 11
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic [2:0]      c__to_push_4a,
  input  logic [34:0]     st__to_push_4a,
  input  logic [10:0]     st__to_pop_4a,
  input  logic            kill_4a,
  input  logic [31:0]     branch_target_4a,
  input  logic [SP_W-1:0] rd_off0_2a,
  input  logic [SP_W-1:0] rd_off1_2a,
  output logic [34:0]     rd_data0_2a,
  output logic [34:0]     rd_data1_2a,
  output logic [SP_W-1:0] sp_5a,
  output logic            redirect_5a,
  output logic [31:0]     redirect_pc_5a,
  output logic            stack_underflow_5a,
  output logic            stack_overflow_5a
);
  localparam int AW  = $clog2(DEPTH);
  // arithmetic width wide enough for the 11-bit pop count and SP plus a carry
  localparam int CW  = (SP_W + 1 > 12) ? SP_W + 1 : 12;
  localparam int NRD = 2;

  typedef logic [34:0] entry_t;

  entry_t          r_mem [DEPTH];
  logic [SP_W-1:0] r_sp;
  logic            r_redirect;
  logic [31:0]     r_redirect_pc;
  logic            r_uf;
  logic            r_of;

  logic            w_push, w_faulted, w_uf, w_of, w_commit, w_wr;
  logic [CW-1:0]   w_sp_x, w_pop_x, w_sp_next, w_wr_full;
  logic [AW-1:0]   w_wr_addr;
  logic [NRD-1:0][SP_W-1:0] w_off;
  logic [NRD-1:0][34:0]     w_rd;

  assign w_push    = (c__to_push_4a != `UC_PUSHNONE);
  assign w_faulted = r_uf | r_of;
  assign w_sp_x    = CW'(r_sp);
  assign w_pop_x   = CW'(st__to_pop_4a);
  assign w_sp_next = w_sp_x - w_pop_x + CW'(w_push);
  // underflow wins when both conditions hold; nothing new is flagged once faulted
  assign w_uf      = ~w_faulted & (w_pop_x > w_sp_x);
  assign w_of      = ~w_faulted & ~w_uf & (w_sp_next > CW'(DEPTH));
  assign w_commit  = ~w_faulted & ~w_uf & ~w_of;
  assign w_wr      = w_commit & w_push;
  // pop before push: the pushed entry lands in the first popped slot
  assign w_wr_full = w_sp_x - w_pop_x;
  assign w_wr_addr = w_wr_full[AW-1:0];

  // SP, sticky faults and redirect registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_sp          <= '0;
      r_uf          <= 1'b0;
      r_of          <= 1'b0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      if (w_uf)     r_uf <= 1'b1;
      if (w_of)     r_of <= 1'b1;
      if (w_commit) r_sp <= SP_W'(w_sp_next);
      r_redirect <= kill_4a;
      if (kill_4a)  r_redirect_pc <= branch_target_4a;
    end
  end

  // Single write port into the stack array. Any write landing while reset is
  // held goes into storage that SP=0 makes unreadable, so it needs no gating.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[w_wr_addr] <= st__to_push_4a;
  end

  assign w_off[0] = rd_off0_2a;
  assign w_off[1] = rd_off1_2a;

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [CW-1:0] w_off_x, w_addr_x;
    assign w_off_x  = CW'(w_off[g]);
    assign w_addr_x = w_sp_x - CW'(1) - w_off_x;
    // off >= sp means the slot is empty; a same-slot push this cycle is forwarded
    assign w_rd[g]  = (w_off_x >= w_sp_x)                ? '0 :
                      (w_wr && (w_addr_x == w_wr_full))  ? st__to_push_4a :
                                                           r_mem[w_addr_x[AW-1:0]];
  end

  assign rd_data0_2a        = w_rd[0];
  assign rd_data1_2a        = w_rd[1];
  assign sp_5a              = r_sp;
  assign redirect_5a        = r_redirect;
  assign redirect_pc_5a     = r_redirect_pc;
  assign stack_underflow_5a = r_uf;
  assign stack_overflow_5a  = r_of;
endmodule

// File: tb/tb_cpu_stack_writeback.sv
// Bench for cpu_stack_writeback: directed scenarios plus randomized traffic
// against a queue-based stack model.
`ifndef UC_PUSHNONE
`define UC_PUSHNONE 3'd0
`endif

module tb_cpu_stack_writeback;
  localparam int DEPTH = 256;
  localparam int SP_W  = 11;

  logic            clk = 1'b0;
  logic            rst_b = 1'b0;
  logic [2:0]      c__to_push_4a = '0;
  logic [34:0]     st__to_push_4a = '0;
  logic [10:0]     st__to_pop_4a = '0;
  logic            kill_4a = 1'b0;
  logic [31:0]     branch_target_4a = '0;
  logic [SP_W-1:0] rd_off0_2a = '0, rd_off1_2a = '0;
  logic [34:0]     rd_data0_2a, rd_data1_2a;
  logic [SP_W-1:0] sp_5a;
  logic            redirect_5a, stack_underflow_5a, stack_overflow_5a;
  logic [31:0]     redirect_pc_5a;

  cpu_stack_writeback #(.DEPTH(DEPTH), .SP_W(SP_W)) dut (
    .clk(clk), .rst_b(rst_b),
    .c__to_push_4a(c__to_push_4a), .st__to_push_4a(st__to_push_4a),
    .st__to_pop_4a(st__to_pop_4a), .kill_4a(kill_4a),
    .branch_target_4a(branch_target_4a),
    .rd_off0_2a(rd_off0_2a), .rd_off1_2a(rd_off1_2a),
    .rd_data0_2a(rd_data0_2a), .rd_data1_2a(rd_data1_2a),
    .sp_5a(sp_5a), .redirect_5a(redirect_5a), .redirect_pc_5a(redirect_pc_5a),
    .stack_underflow_5a(stack_underflow_5a), .stack_overflow_5a(stack_overflow_5a)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: the stack as a queue, q[$] is TOS
  logic [34:0] q[$];
  bit          m_uf, m_of, m_red;
  logic [31:0] m_pc;
  logic [34:0] ro0, ro1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_commit(input int pop, input bit push);
    int n = q.size();
    return !(m_uf || m_of) && (pop <= n) && (n - pop + int'(push) <= DEPTH);
  endfunction

  function automatic logic [34:0] m_read(input int off, input bit push,
                                         input logic [34:0] pd, input int pop);
    int n = q.size();
    int idx;
    if (off >= n) return '0;
    idx = n - 1 - off;
    if (push && m_commit(pop, push) && idx == n - pop) return pd;
    return q[idx];
  endfunction

  task automatic m_step(input int pop, input bit push, input logic [34:0] pd,
                        input bit kill, input logic [31:0] tgt);
    if (!(m_uf || m_of)) begin
      if (pop > q.size()) m_uf = 1'b1;
      else if (q.size() - pop + int'(push) > DEPTH) m_of = 1'b1;
      else begin
        repeat (pop) void'(q.pop_back());
        if (push) q.push_back(pd);
      end
    end
    m_red = kill;
    if (kill) m_pc = tgt;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_sp"},  64'(sp_5a), 64'(q.size()));
    chk({tag, "_uf"},  64'(stack_underflow_5a), 64'(m_uf));
    chk({tag, "_of"},  64'(stack_overflow_5a), 64'(m_of));
    chk({tag, "_red"}, 64'(redirect_5a), 64'(m_red));
    chk({tag, "_pc"},  64'(redirect_pc_5a), 64'(m_pc));
  endtask

  // one clock: drive at negedge, check reads before the edge, registers after
  task automatic cyc(input string tag, input logic [2:0] pc, input logic [34:0] pd,
                     input int pop, input bit kill, input logic [31:0] tgt,
                     input int o0, input int o1);
    bit push = (pc != `UC_PUSHNONE);
    @(negedge clk);
    c__to_push_4a = pc; st__to_push_4a = pd; st__to_pop_4a = 11'(pop);
    kill_4a = kill; branch_target_4a = tgt;
    rd_off0_2a = SP_W'(o0); rd_off1_2a = SP_W'(o1);
    #1;
    ro0 = rd_data0_2a; ro1 = rd_data1_2a;
    chk({tag, "_rd0"}, 64'(ro0), 64'(m_read(o0, push, pd, pop)));
    chk({tag, "_rd1"}, 64'(ro1), 64'(m_read(o1, push, pd, pop)));
    @(posedge clk);
    m_step(pop, push, pd, kill, tgt);
    #1;
    chk_regs(tag);
  endtask

  task automatic push1(input string tag, input logic [34:0] d);
    cyc(tag, 3'd1, d, 0, 1'b0, 32'h0, 0, 1);
  endtask

  task automatic idle(input string tag, input int o0, input int o1);
    cyc(tag, `UC_PUSHNONE, 35'h0, 0, 1'b0, 32'h0, o0, o1);
  endtask

  // asynchronous reset in the middle of a high clock phase
  task automatic do_reset(input string tag);
    #2;
    rst_b = 1'b0;
    c__to_push_4a = `UC_PUSHNONE; st__to_pop_4a = '0; kill_4a = 1'b0;
    rd_off0_2a = '0; rd_off1_2a = '0;
    #1;
    q = {}; m_uf = 0; m_of = 0; m_red = 0; m_pc = '0;
    chk({tag, "_rst_sp"},  64'(sp_5a), 64'd0);
    chk({tag, "_rst_red"}, 64'(redirect_5a), 64'd0);
    chk({tag, "_rst_pc"},  64'(redirect_pc_5a), 64'd0);
    chk({tag, "_rst_uf"},  64'(stack_underflow_5a), 64'd0);
    chk({tag, "_rst_of"},  64'(stack_overflow_5a), 64'd0);
    chk({tag, "_rst_rd0"}, 64'(rd_data0_2a), 64'd0);
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  function automatic logic [34:0] rnd_entry();
    logic [2:0]  t = 3'($urandom_range(7, 0));
    logic [31:0] d = $urandom;
    return {t, d};
  endfunction

  initial begin
    logic [34:0] last;
    q = {}; m_uf = 0; m_of = 0; m_red = 0; m_pc = '0;
    #12;
    chk_regs("init");
    @(negedge clk);
    rst_b = 1'b1;

    // 1: three pushes, read TOS and bottom
    push1("t1a", 35'h1_00000011);
    push1("t1b", 35'h1_00000022);
    push1("t1c", 35'h1_00000033);
    chk("t1_sp", 64'(sp_5a), 64'd3);
    idle("t1r", 0, 2);
    chk("t1_tos", 64'(ro0), 64'h1_00000033);
    chk("t1_bot", 64'(ro1), 64'h1_00000011);

    // 2: pop 2 and push in one cycle
    cyc("t2", 3'd2, 35'h1_00000044, 2, 1'b0, 32'h0, 0, 1);
    chk("t2_sp", 64'(sp_5a), 64'd2);
    idle("t2r", 0, 1);
    chk("t2_tos", 64'(ro0), 64'h1_00000044);
    chk("t2_off1", 64'(ro1), 64'h1_00000011);

    // 3: underflow is sticky and blocks later pushes
    do_reset("t3");
    push1("t3a", 35'h1_00000011);
    cyc("t3u", `UC_PUSHNONE, 35'h0, 2, 1'b0, 32'h0, 0, 1);
    chk("t3_uf", 64'(stack_underflow_5a), 64'd1);
    chk("t3_sp", 64'(sp_5a), 64'd1);
    push1("t3p", 35'h1_00000099);
    chk("t3_sp_hold", 64'(sp_5a), 64'd1);
    idle("t3r", 0, 1);
    chk("t3_tos", 64'(ro0), 64'h1_00000011);

    // 4: fill to DEPTH, then overflow
    do_reset("t4");
    last = '0;
    for (int i = 0; i < DEPTH; i++) begin
      last = rnd_entry();
      push1("t4f", last);
    end
    chk("t4_full", 64'(sp_5a), 64'(DEPTH));
    push1("t4o", rnd_entry());
    chk("t4_of", 64'(stack_overflow_5a), 64'd1);
    chk("t4_sp", 64'(sp_5a), 64'(DEPTH));
    chk("t4_uf", 64'(stack_underflow_5a), 64'd0);
    idle("t4r", 0, DEPTH - 1);
    chk("t4_tos", 64'(ro0), 64'(last));

    // 5: bypass of a same-slot push, and off=sp reads zero
    do_reset("t5");
    push1("t5a", 35'h1_00000011);
    push1("t5b", 35'h1_00000022);
    cyc("t5", 3'd3, 35'h1_00000055, 1, 1'b0, 32'h0, 0, 2);
    chk("t5_byp", 64'(ro0), 64'h1_00000055);
    chk("t5_empty", 64'(ro1), 64'd0);

    // 6: redirect latency, hold, and async reset mid-sequence
    cyc("t6k", `UC_PUSHNONE, 35'h0, 0, 1'b1, 32'h0000_0100, 0, 1);
    chk("t6_red", 64'(redirect_5a), 64'd1);
    chk("t6_pc", 64'(redirect_pc_5a), 64'h100);
    cyc("t6n", 3'd1, 35'h1_00000066, 0, 1'b0, 32'hDEAD_BEEF, 0, 1);
    chk("t6_red0", 64'(redirect_5a), 64'd0);
    chk("t6_pchold", 64'(redirect_pc_5a), 64'h100);
    cyc("t6k2", 3'd1, 35'h1_00000077, 1, 1'b1, 32'h0000_0200, 0, 1);
    do_reset("t6");

    // randomized episodes against the model
    for (int ep = 0; ep < 5; ep++) begin
      for (int c = 0; c < 150; c++) begin
        int n = q.size();
        int pop = ($urandom_range(99, 0) < 3) ? $urandom_range(n + 2, 0)
                                              : $urandom_range(2, 0);
        logic [2:0] pc = ($urandom_range(99, 0) < 60) ? 3'($urandom_range(7, 1))
                                                      : `UC_PUSHNONE;
        cyc("rnd", pc, rnd_entry(), pop, 1'($urandom_range(1, 0)), $urandom,
            $urandom_range(n + 1, 0), $urandom_range(n + 1, 0));
      end
      do_reset("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
